mem_store_checker: RTL
======================

// Module: mem_store_checker
// PURPOSE
//  Synthesizable, parametrised store-bus checker for the superscalar MIPS pipeline.
//  - Watches NPORTS memory-write lanes every clk cycle.
//  - Compares each observed store against a programmable table of expected
//    (address, data) pairs.
//  - Reports done/pass/fail, a failure cause and match counters.
//  - Sits beside the pipeline's data-memory interface in self-checking benches and on FPGA bring-up.
// PARAMETERS
//  NPORTS   2     number of memory-write lanes observed per cycle
//  AW       32    address width
//  DW       32    data width
//  DEPTH    8     expected-table entries
//  TIMEOUT  4096  cycles in RUN before declaring timeout (>=1)
//  STRICT   0     0: non-matching stores ignored; 1: any non-matching store fails
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              synchronous, active-high reset
//  memwrite   in   NPORTS         per-lane store strobe
//  dataadr    in   NPORTS*AW      lane i address at [i*AW +: AW]
//  writedata  in   NPORTS*DW      lane i data at [i*DW +: DW]
//  exp_we     in   1              write expected entry (accepted in IDLE only)
//  exp_idx    in   clog2(DEPTH)   entry index
//  exp_addr   in   AW             expected address
//  exp_data   in   DW             expected data
//  exp_count  in   clog2(DEPTH)+1 entries in use, sampled on start
//  start      in   1              IDLE->RUN (ignored in other states)
//  done       out  1              checking finished (PASS or FAIL)
//  pass       out  1              all expected entries matched
//  fail       out  1              mismatch or timeout
//  fail_cause out  2              0 none, 1 mismatch, 2 timeout
//  fail_addr  out  AW             address of offending store (0 on timeout)
//  fail_data  out  DW             data of offending store (0 on timeout)
//  match_cnt  out  clog2(DEPTH)+1 entries matched so far
//  cycle_cnt  out  clog2(TIMEOUT)+1  cycles spent in RUN, saturating
// BEHAVIOUR
//  - All state updates at posedge clk. Outputs are registered.
//  - Reset: state=IDLE; done, pass, fail, fail_cause, fail_addr, fail_data,
//    match_cnt, cycle_cnt all 0. Latched count := 0. Table contents not reset.
//  - Reset asserted mid-RUN aborts the run with no pass or fail pulse.
//  - FSM states: IDLE, RUN, PASS, FAIL.
//    - IDLE: exp_we writes table[exp_idx].
//      On start: latch exp_count, clear counters, go to RUN.
//      If latched count is 0, go directly to PASS instead.
//    - RUN: each cycle, process lanes in order 0..NPORTS-1 against pointer ptr:
//      - Lane with memwrite=1 and (addr,data)==table[ptr]: ptr++, match_cnt++.
//        A later lane in the same cycle compares against the advanced ptr, so
//        up to NPORTS entries can match per cycle.
//      - STRICT=1 and a strobed lane does not match: go to FAIL, cause=1.
//        Capture that lane's addr/data. Lower lanes' matches in that cycle still count.
//      - STRICT=0: non-matching stores are ignored.
//      - Lanes after ptr reaches count are ignored.
//      - ptr==count after this cycle's lanes: go to PASS.
//      - cycle_cnt increments each RUN cycle. Reaching TIMEOUT goes to FAIL,
//        cause=2, unless the same cycle completes the sequence (PASS has priority).
//    - PASS / FAIL: sticky. done=1 plus pass or fail.
//      start returns to IDLE-equivalent restart: counters cleared, RUN entered.
//  - Latency: done/pass/fail are visible the cycle after the completing or failing store is sampled.
//  - exp_we outside IDLE is ignored. exp_count > DEPTH is clamped to DEPTH.
//  - Equality is exact over the full AW/DW bits. X/Z on a strobed lane counts as a mismatch in simulation.
// STRUCTURE
//  - Shared include mips_check_pkg.vh: FSM state encodings; fail_cause codes
//    CHK_NONE/CHK_MISMATCH/CHK_TIMEOUT; clog2 helper macro.
//  - Sub-module store_lane_cmp: combinational, one per lane.
//    Inputs: strobe, addr, data, expected entry.
//    Outputs: hit, miss.
//    The top chains NPORTS instances over successive table entries
//    (table[ptr+i], with a prefix-hit gate).
//  - Table is a DEPTH x (AW+DW) register array. No RAM macro is needed.
// TESTING
//  1. NPORTS=1, STRICT=0; table {84:7}, count=1; stores 80:3 then 84:7 ->
//     pass=1, done=1 one cycle after 84:7; match_cnt=1.
//  2. STRICT=1; table {80:3, 84:7}; stores 80:3, 84:9 ->
//     fail=1, fail_cause=1, fail_addr=84, fail_data=9, match_cnt=1.
//  3. NPORTS=2; table {80:3, 84:7}; both lanes in one cycle (lane0 80:3, lane1 84:7) ->
//     pass next cycle, match_cnt=2. Swapped lanes with STRICT=1 -> fail, cause=1, fail_addr=84.
//  4. TIMEOUT=16; table {84:7}; no stores ->
//     fail_cause=2 after 16 RUN cycles, cycle_cnt=16.
//     Variant: 84:7 on cycle 16 -> pass (priority).
//  5. start with exp_count=0 -> pass the next cycle, match_cnt=0, cycle_cnt=0.
//  6. reset pulsed mid-RUN after one match -> all outputs 0, state IDLE.
//     Next start with the same table reruns correctly without reloading entries.

Source files
------------

// File: rtl/mem_store_checker_pkg.sv
// Shared FSM encoding, failure-cause codes and width helper for the store-bus checker.
package mem_store_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_e;

    localparam logic [1:0] CHK_NONE     = 2'd0;
    localparam logic [1:0] CHK_MISMATCH = 2'd1;
    localparam logic [1:0] CHK_TIMEOUT  = 2'd2;

    // Index width that stays at least one bit for single-entry tables.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/store_lane_cmp.sv
// Combinational compare of one observed store lane against one expected table entry.
module store_lane_cmp #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          strobe,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] exp_addr,
    input  logic [DW-1:0] exp_data,
    output logic          hit,
    output logic          miss
);

    logic eq;

    // Case equality so unknown bits on a strobed lane read as a mismatch.
    assign eq   = ({addr, data} === {exp_addr, exp_data});
    assign hit  = strobe & eq;
    assign miss = strobe & ~eq;

endmodule

// File: rtl/mem_store_checker.sv
// Store-bus checker: matches NPORTS store lanes per cycle against an ordered table of
// expected (address, data) pairs and reports pass/fail, failure cause and counters.
module mem_store_checker
    import mem_store_checker_pkg::*;
#(
    parameter int unsigned NPORTS  = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 4096,
    parameter int unsigned STRICT  = 0,
    localparam int unsigned IW = idx_width(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1,
    localparam int unsigned TW = $clog2(TIMEOUT) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NPORTS-1:0]    memwrite,
    input  logic [NPORTS*AW-1:0] dataadr,
    input  logic [NPORTS*DW-1:0] writedata,
    input  logic                 exp_we,
    input  logic [IW-1:0]        exp_idx,
    input  logic [AW-1:0]        exp_addr,
    input  logic [DW-1:0]        exp_data,
    input  logic [CW-1:0]        exp_count,
    input  logic                 start,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic [1:0]           fail_cause,
    output logic [AW-1:0]        fail_addr,
    output logic [DW-1:0]        fail_data,
    output logic [CW-1:0]        match_cnt,
    output logic [TW-1:0]        cycle_cnt
);

    state_e            state_q, state_d;
    logic [AW+DW-1:0]  tbl [DEPTH];
    logic [CW-1:0]     count_q, count_d, match_d, count_clamped, pos_end;
    logic [TW-1:0]     cycle_d;
    logic              done_d, pass_d, fail_d;
    logic [1:0]        cause_d;
    logic [AW-1:0]     faddr_d, miss_addr;
    logic [DW-1:0]     fdata_d, miss_data;
    logic [NPORTS-1:0] miss_v;

    // Expected table: written only while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if (exp_we && state_q == ST_IDLE) begin
            tbl[exp_idx] <= {exp_addr, exp_data};
        end
    end

    // Lane i checks entry ptr + (hits on lower lanes); in strict mode a miss blocks later lanes.
    for (genvar i = 0; i < NPORTS; i++) begin : g_lane
        logic [CW-1:0]    pos_in, pos_out;
        logic             ok_in, active, hit, miss;
        logic [AW+DW-1:0] entry;

        if (i == 0) begin : g_head
            assign pos_in = match_cnt;
            assign ok_in  = 1'b1;
        end else begin : g_chain
            assign pos_in = g_lane[i-1].pos_out;
            assign ok_in  = (STRICT != 0) ? (g_lane[i-1].ok_in & ~g_lane[i-1].miss) : 1'b1;
        end

        assign active = (pos_in < count_q);
        assign entry  = active ? tbl[IW'(pos_in)] : '0;

        store_lane_cmp #(.AW(AW), .DW(DW)) u_cmp (
            .strobe   (memwrite[i] & active & ok_in),
            .addr     (dataadr[i*AW +: AW]),
            .data     (writedata[i*DW +: DW]),
            .exp_addr (entry[DW +: AW]),
            .exp_data (entry[0 +: DW]),
            .hit      (hit),
            .miss     (miss)
        );

        assign pos_out   = pos_in + CW'(hit);
        assign miss_v[i] = miss;
    end

    assign pos_end       = g_lane[NPORTS-1].pos_out;
    assign count_clamped = (exp_count > CW'(DEPTH)) ? CW'(DEPTH) : exp_count;

    // Lowest missing lane supplies the captured address/data.
    always_comb begin
        miss_addr = '0;
        miss_data = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (miss_v[i]) begin
                miss_addr = dataadr[i*AW +: AW];
                miss_data = writedata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        match_d = match_cnt;
        cycle_d = cycle_cnt;
        done_d  = done;
        pass_d  = pass;
        fail_d  = fail;
        cause_d = fail_cause;
        faddr_d = fail_addr;
        fdata_d = fail_data;

        case (state_q)
            ST_RUN: begin
                match_d = pos_end;
                cycle_d = cycle_cnt + TW'(1);
                if (pos_end == count_q) begin
                    state_d = ST_PASS;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else if (STRICT != 0 && |miss_v) begin
                    state_d = ST_FAIL;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    cause_d = CHK_MISMATCH;
                    faddr_d = miss_addr;
                    fdata_d = miss_data;
                end else if (cycle_d == TW'(TIMEOUT)) begin
                    state_d = ST_FAIL;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    cause_d = CHK_TIMEOUT;
                    faddr_d = '0;
                    fdata_d = '0;
                end
            end
            default: begin
                // IDLE, PASS and FAIL all restart the same way on start.
                if (start) begin
                    count_d = count_clamped;
                    match_d = '0;
                    cycle_d = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    cause_d = CHK_NONE;
                    faddr_d = '0;
                    fdata_d = '0;
                    if (count_clamped == '0) begin
                        state_d = ST_PASS;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            match_cnt  <= '0;
            cycle_cnt  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_cause <= CHK_NONE;
            fail_addr  <= '0;
            fail_data  <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            match_cnt  <= match_d;
            cycle_cnt  <= cycle_d;
            done       <= done_d;
            pass       <= pass_d;
            fail       <= fail_d;
            fail_cause <= cause_d;
            fail_addr  <= faddr_d;
            fail_data  <= fdata_d;
        end
    end

endmodule
